// File: rtl/fibbi_scan_ctrl.sv
// rtl/fibbi_scan_ctrl.sv - steps an external 4-bit detector over a value range and collects its F results
module fibbi_scan_ctrl #(
    parameter int STEP_DIV = 1,
    parameter int DIV_W    = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  lo,
    input  logic [3:0]  hi,
    output logic [3:0]  det_in,
    input  logic        det_f,
    output logic        busy,
    output logic        done,
    output logic [4:0]  hit_count,
    output logic [3:0]  first_hit,
    output logic        first_valid,
    output logic [15:0] hit_mask
);

    localparam logic [DIV_W-1:0] LP_PACE_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] LP_PACE_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_hi;
    logic [3:0]        r_det_in;
    logic [DIV_W-1:0]  r_pace;
    logic [4:0]        r_hit_count;
    logic [3:0]        r_first_hit;
    logic              r_first_valid;
    logic [15:0]       r_hit_mask;
    logic              w_pace_last;
    logic              w_at_end;

    // A sample happens on the last cycle of each value's dwell period.
    assign w_pace_last = (r_pace == LP_PACE_LAST);
    assign w_at_end    = (r_det_in == r_hi);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_pace_last && w_at_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == S_SCAN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi          <= 4'd0;
            r_det_in      <= 4'd0;
            r_pace        <= '0;
            r_hit_count   <= 5'd0;
            r_first_hit   <= 4'd0;
            r_first_valid <= 1'b0;
            r_hit_mask    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hi          <= hi;
                        r_det_in      <= lo;
                        r_pace        <= '0;
                        r_hit_count   <= 5'd0;
                        r_first_hit   <= 4'd0;
                        r_first_valid <= 1'b0;
                        r_hit_mask    <= 16'd0;
                    end
                end
                S_SCAN: begin
                    if (!w_pace_last) begin
                        r_pace <= r_pace + LP_PACE_ONE;
                    end else begin
                        if (det_f) begin
                            r_hit_mask[r_det_in] <= 1'b1;
                            r_hit_count          <= r_hit_count + 5'd1;
                            if (!r_first_valid) begin
                                r_first_hit   <= r_det_in;
                                r_first_valid <= 1'b1;
                            end
                        end
                        // The last value stays on det_in after the scan ends.
                        if (!w_at_end) begin
                            r_det_in <= r_det_in + 4'd1;
                            r_pace   <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign det_in      = r_det_in;
    assign hit_count   = r_hit_count;
    assign first_hit   = r_first_hit;
    assign first_valid = r_first_valid;
    assign hit_mask    = r_hit_mask;

endmodule

// File: tb/tb_fibbi_scan_ctrl.sv
// tb/tb_fibbi_scan_ctrl.sv - randomized and directed checks of fibbi_scan_ctrl against a range-walk model
module tb_fibbi_scan_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start1, start4;
    logic [3:0]  lo1, hi1, lo4, hi4;
    logic [15:0] tt1, tt4;
    logic [3:0]  det_in1, det_in4;
    logic        det_f1, det_f4;
    logic        busy1, busy4, done1, done4;
    logic [4:0]  hit_count1, hit_count4;
    logic [3:0]  first_hit1, first_hit4;
    logic        first_valid1, first_valid4;
    logic [15:0] hit_mask1, hit_mask4;

    int total = 0;
    int bad   = 0;

    assign det_f1 = tt1[det_in1];
    assign det_f4 = tt4[det_in4];

    fibbi_scan_ctrl #(.STEP_DIV(1), .DIV_W(27)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .lo(lo1), .hi(hi1),
        .det_in(det_in1), .det_f(det_f1), .busy(busy1), .done(done1),
        .hit_count(hit_count1), .first_hit(first_hit1),
        .first_valid(first_valid1), .hit_mask(hit_mask1)
    );

    fibbi_scan_ctrl #(.STEP_DIV(4), .DIV_W(27)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .lo(lo4), .hi(hi4),
        .det_in(det_in4), .det_f(det_f4), .busy(busy4), .done(done4),
        .hit_count(hit_count4), .first_hit(first_hit4),
        .first_valid(first_valid4), .hit_mask(hit_mask4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic fib_f(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (~a & ~c) | (~b & ~c) | (~b & ~d);
    endfunction

    function automatic logic [15:0] fib_table();
        logic [15:0] t;
        for (int v = 0; v < 16; v++) t[v] = fib_f(4'(v));
        return t;
    endfunction

    // Walk the range in scan order and tally results from the truth table.
    task automatic model(input logic [3:0] lo, input logic [3:0] hi, input logic [15:0] tt,
                         output int n, output logic [4:0] cnt, output logic [3:0] fh,
                         output logic fv, output logic [15:0] mask);
        n = ((int'(hi) - int'(lo) + 16) % 16) + 1;
        cnt = 0; fh = 0; fv = 0; mask = 0;
        for (int i = 0; i < n; i++) begin
            logic [3:0] v;
            v = 4'((int'(lo) + i) % 16);
            if (tt[v]) begin
                cnt++;
                mask[v] = 1'b1;
                if (!fv) begin fh = v; fv = 1'b1; end
            end
        end
    endtask

    task automatic drive(input bit use4, input logic s, input logic [3:0] l, input logic [3:0] h);
        if (use4) begin start4 = s; lo4 = l; hi4 = h; end
        else begin start1 = s; lo1 = l; hi1 = h; end
    endtask

    task automatic check_results(input bit use4, input string tag, input logic [4:0] cnt,
                                 input logic [3:0] fh, input logic fv, input logic [15:0] mask);
        chk({tag, ".cnt"},   use4 ? hit_count4 : hit_count1, cnt);
        chk({tag, ".fv"},    use4 ? first_valid4 : first_valid1, fv);
        if (fv) chk({tag, ".fh"}, use4 ? first_hit4 : first_hit1, fh);
        chk({tag, ".mask"},  use4 ? hit_mask4 : hit_mask1, mask);
    endtask

    // Runs one scan, checking det_in each cycle and the done timing; poke>0 re-pulses start at that cycle.
    task automatic scan_check(input bit use4, input logic [3:0] lo, input logic [3:0] hi,
                              input logic [15:0] tt, input int poke, input string tag);
        int s, n;
        logic [4:0]  cnt;
        logic [3:0]  fh;
        logic        fv;
        logic [15:0] mask;
        logic [3:0]  ev;
        s = use4 ? 4 : 1;
        model(lo, hi, tt, n, cnt, fh, fv, mask);
        if (use4) tt4 = tt; else tt1 = tt;
        @(negedge clk);
        drive(use4, 1'b1, lo, hi);
        @(posedge clk); #1;
        drive(use4, 1'b0, lo, hi);
        chk({tag, ".busy_k"},  use4 ? busy4 : busy1, 1);
        chk({tag, ".det_k"},   use4 ? det_in4 : det_in1, lo);
        chk({tag, ".clr_cnt"}, use4 ? hit_count4 : hit_count1, 0);
        chk({tag, ".clr_msk"}, use4 ? hit_mask4 : hit_mask1, 0);
        chk({tag, ".clr_fv"},  use4 ? first_valid4 : first_valid1, 0);
        for (int t = 1; t < n * s; t++) begin
            @(posedge clk); #1;
            ev = 4'((int'(lo) + t / s) % 16);
            chk({tag, ".det"},  use4 ? det_in4 : det_in1, ev);
            chk({tag, ".busy"}, use4 ? busy4 : busy1, 1);
            chk({tag, ".done_early"}, use4 ? done4 : done1, 0);
            if (t == poke) drive(use4, 1'b1, ~lo, lo);
            else drive(use4, 1'b0, lo, hi);
        end
        drive(use4, 1'b0, lo, hi);
        @(posedge clk); #1;
        chk({tag, ".done"},     use4 ? done4 : done1, 1);
        chk({tag, ".busy_end"}, use4 ? busy4 : busy1, 0);
        chk({tag, ".det_hold"}, use4 ? det_in4 : det_in1, hi);
        @(posedge clk); #1;
        chk({tag, ".done_1cyc"}, use4 ? done4 : done1, 0);
        chk({tag, ".busy_idle"}, use4 ? busy4 : busy1, 0);
        check_results(use4, tag, cnt, fh, fv, mask);
    endtask

    initial begin
        logic [15:0] tt_fib;
        int          done_seen;
        tt_fib = fib_table();
        tt1 = 16'd0; tt4 = 16'd0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b1, 1'b0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy1, 0);
        chk("rst.done", done1, 0);
        chk("rst.det",  det_in1, 0);
        check_results(1'b0, "rst", 5'd0, 4'd0, 1'b0, 16'd0);
        chk("rst.busy4", busy4, 0);
        @(negedge clk);
        reset = 1'b0;

        scan_check(1'b0, 4'd0, 4'd15, tt_fib, 0, "full");
        check_results(1'b0, "full_spec", 5'd8, 4'd0, 1'b1, 16'h0737);

        scan_check(1'b0, 4'd14, 4'd1, tt_fib, 0, "wrap");
        check_results(1'b0, "wrap_spec", 5'd2, 4'd0, 1'b1, 16'h0003);

        scan_check(1'b0, 4'd3, 4'd3, tt_fib, 0, "one3");
        check_results(1'b0, "one3_spec", 5'd0, 4'd0, 1'b0, 16'h0000);

        scan_check(1'b0, 4'd8, 4'd8, tt_fib, 0, "one8");
        check_results(1'b0, "one8_spec", 5'd1, 4'd8, 1'b1, 16'h0100);

        scan_check(1'b1, 4'd4, 4'd6, tt_fib, 0, "pace");
        check_results(1'b1, "pace_spec", 5'd2, 4'd4, 1'b1, 16'h0030);

        scan_check(1'b0, 4'd0, 4'd15, tt_fib, 5, "poke");
        check_results(1'b0, "poke_spec", 5'd8, 4'd0, 1'b1, 16'h0737);

        scan_check(1'b0, 4'd5, 4'd4, tt_fib, 0, "all16");

        // Reset lands on the edge after cycle 6 of a full scan.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd0, 4'd15);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 4'd15);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstmid.busy", busy1, 0);
        chk("rstmid.done", done1, 0);
        chk("rstmid.det",  det_in1, 0);
        check_results(1'b0, "rstmid", 5'd0, 4'd0, 1'b0, 16'd0);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done1) done_seen++;
        end
        chk("rstmid.no_done", done_seen, 0);
        scan_check(1'b0, 4'd0, 4'd15, tt_fib, 0, "after_rst");

        for (int r = 0; r < 20; r++)
            scan_check(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)),
                       16'($urandom), int'($urandom_range(8)), "rnd1");
        for (int r = 0; r < 4; r++)
            scan_check(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)),
                       16'($urandom), int'($urandom_range(20)), "rnd4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fibbi_scan_ctrl.md
Name: fibbi_scan_ctrl

Overview:
- Sequencer that drives the 4-bit combinational Fibonacci-style detector (inputs A,B,C,D; output F) over a programmable value range.
- Collects per-value match results and reports them to the board-level top (LEDs / 7-seg).
- The detector stays external and combinational. This block owns its inputs, samples its output, and runs a start/busy/done handshake.

Parameters:
- STEP_DIV, 1, clock cycles spent on each value before sampling (≥1; large values slow the scan for visual display).
- DIV_W, 27, width of the pace counter (must hold STEP_DIV-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- lo  input  4  first value of the range; captured on start accept.
- hi  input  4  last value of the range; captured on start accept.
- det_in  output  4  value driven to the detector; bit3=A, bit2=B, bit1=C, bit0=D.
- det_f  input  1  detector output F for the current det_in.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when the scan completes.
- hit_count  output  5  number of values with F=1 (0..16).
- first_hit  output  4  lowest-ordered value in the scan with F=1.
- first_valid  output  1  first_hit holds a valid value.
- hit_mask  output  16  bit v set when value v returned F=1.

Behaviour:
- Reset, synchronous: state=IDLE; det_in=0, busy=0, done=0, hit_count=0, first_hit=0, first_valid=0, hit_mask=0, pace=0.
- Reset dominates everything. Reset mid-scan aborts the scan, clears all outputs and produces no done pulse.

State machine: IDLE, SCAN, DONE.
- IDLE, start=1 at an edge:
  - capture lo and hi; det_in<=lo; pace<=0; busy<=1.
  - clear hit_count, first_hit, first_valid and hit_mask.
  - go to SCAN.
- IDLE, start=0: hold all results.
- SCAN, each edge:
  - If pace<STEP_DIV-1: pace<=pace+1.
  - Otherwise sample det_f for the current det_in:
    - if det_f=1: hit_mask[det_in]<=1; hit_count<=hit_count+1; if first_valid=0 then first_hit<=det_in and first_valid<=1.
    - Then, if det_in==captured hi: busy<=0, done<=1, go to DONE.
    - Else: det_in<=det_in+1 (4-bit modulo, 15 wraps to 0); pace<=0.
- DONE: done<=0; go to IDLE. Results hold until the next accepted start. det_in holds its last value.
- start while in SCAN or DONE is ignored. It is not queued.

Range rules:
- Scan length N = ((hi-lo) mod 16)+1.
- lo>hi wraps through 15 to 0. Example: lo=14, hi=1 scans 14,15,0,1.
- lo==hi scans exactly one value.
- lo=hi+1 (mod 16) scans all 16 values.
- "First" means first in scan order, not the numerically smallest.

Timing and widths:
- Timing from the start-accept edge k: busy=1 and det_in=lo from edge k. Samples occur at edges k+STEP_DIV, k+2·STEP_DIV, … After edge k+N·STEP_DIV, done=1 and busy=0 for one cycle.
- det_f is sampled at the clock edge only, so the detector's combinational delay must settle within one cycle.
- hit_count is 5 bits and cannot overflow (maximum 16).

Test Plan:
- Full scan with STEP_DIV=1, lo=0, hi=15, bench models F=(~A&~C)|(~B&~C)|(~B&~D) → done pulses 16 cycles after the start edge for exactly 1 cycle; hit_count=8, hit_mask=16'h0737, first_hit=0, first_valid=1.
- Wrap range with lo=14, hi=1 → values 14,15,0,1 presented in order; hit_count=2, hit_mask=16'h0003, first_hit=0; done 4 cycles after start.
- Single-value scans:
  - lo=hi=3 → hit_count=0, first_valid=0, hit_mask=0; done 1 cycle after start.
  - lo=hi=8 → hit_count=1, first_hit=8, hit_mask=16'h0100.
- Pacing with STEP_DIV=4, lo=4, hi=6 → each of det_in=4,5,6 held 4 cycles; done 12 cycles after start; hit_count=2 (values 4 and 5), hit_mask=16'h0030.
- start pulsed again at cycle 5 of the full scan → ignored, and results match the first scenario. A new start after done clears the results and rescans.
- reset asserted at cycle 7 of the full scan → next cycle: busy=0, all results 0, no done pulse. A start after reset release gives a normal full scan.
